priority_scheduler: RTL
=======================

PRIORITY_SCHEDULER -- requirements
Module: priority_scheduler

Interface
REQ-001 Parameter INPUTS, default 3, is the number of requesters (2..8).
REQ-002 Parameter IDX_WIDTH, default $clog2(INPUTS), is the width of the granted index.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 Port req  input  INPUTS  holds per-requester request bits, sampled every clock and sticky-latched.
REQ-006 Port rr_en  input  1  selects the arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 Port gnt_ready  input  1  is the consumer's acceptance of the current grant.
REQ-008 Port gnt_valid  output  1  indicates a grant is being offered.
REQ-009 Port gnt_idx  output  IDX_WIDTH  is the binary index of the granted requester.
REQ-010 Port gnt_onehot  output  INPUTS  is a one-hot copy of gnt_idx, all-zero when gnt_valid=0.
REQ-011 Port pending  output  INPUTS  shows the registered pending-request vector.
REQ-012 Port busy  output  1  is high when pending != 0 or gnt_valid=1.

Function
REQ-013 The pending register shall update each cycle as pending_next = (pending & ~clear_mask) | req, where clear_mask is the one-hot of gnt_idx in a handshake cycle and zero otherwise.
REQ-014 A handshake shall occur in a cycle where gnt_valid=1 and gnt_ready=1 are both sampled high.
REQ-015 The FSM shall have exactly two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-016 In IDLE with registered pending != 0, the scheduler shall select a winner, register gnt_idx/gnt_onehot, and enter GRANT on that edge.
REQ-017 In IDLE with pending == 0, the FSM shall remain in IDLE, with gnt_idx holding its last value and gnt_onehot = 0.
REQ-018 Selection shall use the registered pending only, never raw req, so a req pulse reaches gnt_valid=1 two edges after it is sampled.
REQ-019 In fixed mode, the winner shall be the highest set index in pending.
REQ-020 In round-robin mode, the winner shall be the first set bit of pending searched in the order last-1, last-2, ..., 0, INPUTS-1, ..., last, where last is the index of the most recent handshake.
REQ-021 The last pointer shall update only on a handshake, to gnt_idx, in both modes.
REQ-022 rr_en shall be sampled only in IDLE at selection time; a change during GRANT shall have no effect on the current grant.
REQ-023 In GRANT without a handshake, gnt_valid, gnt_idx and gnt_onehot shall hold stable regardless of req, rr_en or pending changes.
REQ-024 On a handshake, the FSM shall return to IDLE, giving exactly one bubble cycle (gnt_valid=0) between consecutive grants.
REQ-025 If req[gnt_idx]=1 in the handshake cycle, pending[gnt_idx] shall remain set (re-arm wins over clear).
REQ-026 A request for an already-pending bit shall be absorbed, not counted; at most one outstanding grant exists per requester.
REQ-027 Index arithmetic for the round-robin wrap shall be modulo INPUTS, including non-power-of-two INPUTS; gnt_idx shall never exceed INPUTS-1.

Reset
REQ-028 While rst_n=0 at a rising edge, the following shall be forced: state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, pending=0, last=0, busy=0; req is ignored on that edge.
REQ-029 Reset asserted during GRANT shall abort the grant without a handshake; the pending request is discarded.
REQ-030 With last=0 after reset, the first round-robin search order shall be INPUTS-1 downward.

Verification (INPUTS=3)
REQ-031 Reset scenario: rst_n=0 for 2 edges with req=111 -> all outputs 0 throughout; first edge after release -> pending=111; next edge -> gnt_valid=1, gnt_idx=2.
REQ-032 Fixed-priority scenario: rr_en=0, gnt_ready=1, single-cycle req=101 -> grants idx 2 then 0, each gnt_valid high 1 cycle with 1 bubble between; pending 101->001->000; busy falls after the second handshake.
REQ-033 Backpressure scenario: grant idx 1 offered, gnt_ready=0 for 5 cycles, req[2] pulsed during the wait -> gnt_idx stays 1 and gnt_onehot stays 010; pending becomes 110; after ready, next grant is idx 2.
REQ-034 Round-robin scenario: rr_en=1, req held 111, gnt_ready=1 -> grant sequence 2,1,0,2,1,0.
REQ-035 Re-arm scenario: fixed mode, only req[1] active, req[1]=1 again in the handshake cycle -> pending[1] stays 1 and idx 1 is granted again after the bubble.
REQ-036 Reset mid-grant scenario: rst_n=0 while gnt_valid=1, idx 0 -> next edge gnt_valid=0, pending=000; no grant follows after release unless req is reasserted.

Source files
------------

// File: rtl/priority_scheduler.sv
// rtl/priority_scheduler.sv - sticky-request scheduler with fixed/round-robin grant selection
//
// Collects per-requester request bits into a pending register and offers one
// grant at a time through a valid/ready handshake. Each requester holds at most
// one outstanding grant.
//
// Parameters:
//   INPUTS     number of requesters (2..8)
//   IDX_WIDTH  width of the granted index
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   req         per-requester request bits, sticky-latched into pending
//   rr_en       0 = fixed priority (highest index wins), 1 = round-robin
//   gnt_ready   consumer accepts the current grant
//   gnt_valid   grant offered
//   gnt_idx     binary index of the granted requester
//   gnt_onehot  one-hot copy of gnt_idx, zero while no grant is offered
//   pending     registered pending-request vector
//   busy        pending != 0 or a grant is offered

module priority_scheduler #(
  parameter int INPUTS    = 3,
  parameter int IDX_WIDTH = $clog2(INPUTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INPUTS-1:0]    req,
  input  logic                 rr_en,
  input  logic                 gnt_ready,
  output logic                 gnt_valid,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic [INPUTS-1:0]    gnt_onehot,
  output logic [INPUTS-1:0]    pending,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] last;

  logic                 handshake;
  logic [INPUTS-1:0]    clear_mask;
  logic [IDX_WIDTH-1:0] fixed_idx;
  logic [IDX_WIDTH-1:0] rr_idx;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [INPUTS-1:0]    sel_onehot;

  assign handshake = gnt_valid & gnt_ready;

  // gnt_onehot is already the one-hot of gnt_idx while a grant is offered.
  assign clear_mask = handshake ? gnt_onehot : '0;

  assign busy = (|pending) | gnt_valid;

  // Fixed priority: the highest set index wins, so later loop hits override.
  always_comb begin
    fixed_idx = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (pending[i]) begin
        fixed_idx = IDX_WIDTH'(i);
      end
    end
  end

  // Round-robin: search last-1, last-2, ..., wrapping modulo INPUTS, ending at
  // last itself. last + INPUTS - k stays in [0, 2*INPUTS-1], so one conditional
  // subtraction gives the modulo even for non-power-of-two INPUTS.
  always_comb begin
    logic                 found;
    int                   cand;
    logic [IDX_WIDTH-1:0] cand_idx;
    rr_idx   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= INPUTS; k++) begin
      cand = int'(last) + INPUTS - k;
      if (cand >= INPUTS) begin
        cand = cand - INPUTS;
      end
      cand_idx = IDX_WIDTH'(cand);
      if (!found && pending[cand_idx]) begin
        rr_idx = cand_idx;
        found  = 1'b1;
      end
    end
  end

  assign sel_idx    = rr_en ? rr_idx : fixed_idx;
  assign sel_onehot = {{(INPUTS-1){1'b0}}, 1'b1} << sel_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      pending    <= '0;
      last       <= '0;
    end else begin
      // A request arriving in the handshake cycle re-arms its bit, so OR-in
      // req after the clear.
      pending <= (pending & ~clear_mask) | req;

      case (state)
        IDLE: begin
          // Selection looks at the registered pending only; rr_en matters
          // only here, so mode changes during GRANT cannot disturb a grant.
          if (|pending) begin
            gnt_idx    <= sel_idx;
            gnt_onehot <= sel_onehot;
            gnt_valid  <= 1'b1;
            state      <= GRANT;
          end else begin
            gnt_onehot <= '0;
            gnt_valid  <= 1'b0;
          end
        end

        GRANT: begin
          // Outputs hold until accepted; returning to IDLE yields the single
          // bubble cycle between consecutive grants.
          if (gnt_ready) begin
            last       <= gnt_idx;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            state      <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          gnt_valid  <= 1'b0;
          gnt_onehot <= '0;
        end
      endcase
    end
  end

endmodule
